// File: rtl/bsg_mem_1r1w_sync_init_pkg.sv
// Shared types and constants for the self-initialising branch-history memory.
// Each row holds 2-bit counters; the clear sweep loads every counter with weak not-taken.
package bsg_mem_1r1w_sync_init_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int          ctr_width_lp = 2;
  localparam logic [1:0]  init_val_lp  = 2'b01;

  // Misprediction sets lo; hi flips only when a misprediction lands on an already-weak counter.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic correct);
    ctr_update = {ctr[1] ^ (~correct & ctr[0]), ~correct};
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_init_prims.sv
// Basic building blocks used by the branch-history memory:
// clearable up-counter, enabled flop and a 1R1W synchronous RAM.
module bsg_counter_clear_up #(
  parameter int width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;

  // Sweep counter: clear wins over increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (up_i) begin
      count_q <= count_q + width_p'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

module bsg_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  // Enabled register, cleared by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign data_o = data_q;

endmodule

module bsg_mem_1r1w_sync #(
  parameter int width_p      = 8,
  parameter int els_p        = 512,
  parameter int addr_width_p = 9
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic                    r_v_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] r_data_q;

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  // Read data register holds the last read while r_v_i is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data_q <= '0;
    end else if (r_v_i) begin
      r_data_q <= mem_q[r_addr_i];
    end else begin
      r_data_q <= r_data_q;
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/bsg_mem_1r1w_sync_init.sv
// Branch-history table: 1R1W sync memory of 2-bit counters, cleared by a
// post-reset sweep before updates are accepted.
module bsg_mem_1r1w_sync_init
  import bsg_mem_1r1w_sync_init_pkg::*;
#(
  parameter int         idx_width_p    = 9,
  parameter int         row_els_p      = 4,
  parameter int         offset_width_p = 2,
  parameter logic [1:0] init_val_p     = init_val_lp,
  localparam int        row_width_lp   = ctr_width_lp * row_els_p,
  localparam int        offset_w_lp    = (offset_width_p == 0) ? 1 : offset_width_p
) (
  input  logic                    clock,
  input  logic                    rst,
  output logic                    init_done_o,
  input  logic                    w_v_i,
  input  logic [idx_width_p-1:0]  w_idx_i,
  input  logic [offset_w_lp-1:0]  w_offset_i,
  input  logic [row_width_lp-1:0] w_val_i,
  input  logic                    correct_i,
  output logic                    w_yumi_o,
  input  logic                    r_v_i,
  input  logic [idx_width_p-1:0]  r_idx_i,
  input  logic [offset_w_lp-1:0]  r_offset_i,
  output logic [row_width_lp-1:0] r_val_o,
  output logic                    pred_o
);

  localparam int els_lp = 2 ** idx_width_p;

  state_e                  state_q;
  logic [idx_width_p-1:0]  count_s;
  logic [offset_w_lp-1:0]  offset_q;
  logic                    same_s;
  logic                    clearing_s;
  logic                    mem_w_v_s;
  logic [idx_width_p-1:0]  mem_w_addr_s;
  logic [row_width_lp-1:0] w_data_s;

  // Sweep sequencing; RUN is held until the next reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= RESET;
    end else begin
      case (state_q)
        RESET:   state_q <= CLEAR;
        CLEAR:   state_q <= (count_s == idx_width_p'(els_lp - 1)) ? RUN : CLEAR;
        RUN:     state_q <= RUN;
        default: state_q <= RESET;
      endcase
    end
  end

  bsg_counter_clear_up #(.width_p(idx_width_p)) sweep_ctr (
    .clk_i   (clock),
    .reset_i (rst),
    .clear_i (state_q == RESET),
    .up_i    (state_q == CLEAR),
    .count_o (count_s)
  );

  assign clearing_s   = (state_q == CLEAR);
  assign init_done_o  = (state_q == RUN);
  assign same_s       = r_v_i & w_v_i & (r_idx_i == w_idx_i);
  assign w_yumi_o     = init_done_o & w_v_i & ~same_s;
  assign mem_w_v_s    = clearing_s | w_yumi_o;
  assign mem_w_addr_s = clearing_s ? count_s : w_idx_i;

  for (genvar i = 0; i < row_els_p; i++) begin : g_ctr
    logic [1:0] old_s;
    logic       hit_s;
    assign old_s = w_val_i[ctr_width_lp*i +: ctr_width_lp];
    assign hit_s = (row_els_p == 1) ? 1'b1 : (w_offset_i == offset_w_lp'(i));
    assign w_data_s[ctr_width_lp*i +: ctr_width_lp] =
      clearing_s ? init_val_p : (hit_s ? ctr_update(old_s, correct_i) : old_s);
  end

  bsg_mem_1r1w_sync #(
    .width_p      (row_width_lp),
    .els_p        (els_lp),
    .addr_width_p (idx_width_p)
  ) mem (
    .clk_i    (clock),
    .reset_i  (rst),
    .w_v_i    (mem_w_v_s),
    .w_addr_i (mem_w_addr_s),
    .w_data_i (w_data_s),
    .r_v_i    (r_v_i),
    .r_addr_i (r_idx_i),
    .r_data_o (r_val_o)
  );

  // Offset captured alongside the read so pred_o tracks the held row.
  bsg_dff #(.width_p(offset_w_lp)) offset_reg (
    .clk_i   (clock),
    .reset_i (rst),
    .en_i    (r_v_i),
    .data_i  (r_offset_i),
    .data_o  (offset_q)
  );

  if (row_els_p == 1) begin : g_pred_one
    assign pred_o = r_val_o[1];
  end else begin : g_pred_sel
    assign pred_o = r_val_o[{offset_q, 1'b1}];
  end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_init.sv
// Directed bench for bsg_mem_1r1w_sync_init at default parameters.
module tb_bsg_mem_1r1w_sync_init;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       init_done_o;
  logic       w_v_i = 1'b0;
  logic [8:0] w_idx_i = 9'd0;
  logic [1:0] w_offset_i = 2'd0;
  logic [7:0] w_val_i = 8'h00;
  logic       correct_i = 1'b0;
  logic       w_yumi_o;
  logic       r_v_i = 1'b0;
  logic [8:0] r_idx_i = 9'd0;
  logic [1:0] r_offset_i = 2'd0;
  logic [7:0] r_val_o;
  logic       pred_o;

  int n_asserts = 0;
  int n_fails   = 0;
  int n_cyc;

  always #5 clock = ~clock;

  bsg_mem_1r1w_sync_init dut (
    .clock       (clock),
    .rst         (rst),
    .init_done_o (init_done_o),
    .w_v_i       (w_v_i),
    .w_idx_i     (w_idx_i),
    .w_offset_i  (w_offset_i),
    .w_val_i     (w_val_i),
    .correct_i   (correct_i),
    .w_yumi_o    (w_yumi_o),
    .r_v_i       (r_v_i),
    .r_idx_i     (r_idx_i),
    .r_offset_i  (r_offset_i),
    .r_val_o     (r_val_o),
    .pred_o      (pred_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [8:0] idx, input logic [1:0] off);
    r_v_i = 1'b1; r_idx_i = idx; r_offset_i = off;
    tick();
    r_v_i = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [8:0] idx, input logic [1:0] off,
                          input logic [7:0] val, input logic corr, input logic exp_yumi);
    w_v_i = 1'b1; w_idx_i = idx; w_offset_i = off; w_val_i = val; correct_i = corr;
    #1;
    check(tag, {31'd0, w_yumi_o}, {31'd0, exp_yumi});
    tick();
    w_v_i = 1'b0;
  endtask

  // Counts rising edges until init_done_o, bounded so a stuck sweep still ends.
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done_o && cycles < 600) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(); tick();
    check("reset_init_done", {31'd0, init_done_o}, 32'd0);
    check("reset_yumi", {31'd0, w_yumi_o}, 32'd0);
    check("reset_r_val", {24'd0, r_val_o}, 32'd0);
    check("reset_pred", {31'd0, pred_o}, 32'd0);

    // 1: full sweep then all rows hold weak not-taken
    rst = 1'b0;
    wait_init(n_cyc);
    check("sweep_cycles", n_cyc, 32'd513);
    do_read(9'd0, 2'd0);   check("row0", {24'd0, r_val_o}, 32'h55);
    do_read(9'd255, 2'd0); check("row255", {24'd0, r_val_o}, 32'h55);
    do_read(9'd511, 2'd0); check("row511", {24'd0, r_val_o}, 32'h55);

    // 2: mispredict on weak counter -> strong
    do_write("yumi_w3a", 9'd3, 2'd1, 8'h55, 1'b0, 1'b1);
    do_read(9'd3, 2'd1);
    check("row3_5d", {24'd0, r_val_o}, 32'h5D);
    check("pred_row3_off1", {31'd0, pred_o}, 32'd1);

    // 3: 11 -> 01 on mispredict, 01 -> 00 on correct
    do_write("yumi_w3b", 9'd3, 2'd1, 8'h5D, 1'b0, 1'b1);
    do_read(9'd3, 2'd1);
    check("row3_55", {24'd0, r_val_o}, 32'h55);
    check("pred_row3_weak", {31'd0, pred_o}, 32'd0);
    do_write("yumi_w3c", 9'd3, 2'd1, 8'h55, 1'b1, 1'b1);
    do_read(9'd3, 2'd1);
    check("row3_51", {24'd0, r_val_o}, 32'h51);

    // 4: same-row read/write conflict drops the write
    r_v_i = 1'b1; r_idx_i = 9'd7;
    do_write("yumi_conflict", 9'd7, 2'd0, 8'h55, 1'b0, 1'b0);
    r_v_i = 1'b0;
    check("conflict_read", {24'd0, r_val_o}, 32'h55);
    do_read(9'd7, 2'd0);
    check("row7_unchanged", {24'd0, r_val_o}, 32'h55);
    r_v_i = 1'b1; r_idx_i = 9'd8;
    do_write("yumi_diff_row", 9'd7, 2'd0, 8'h55, 1'b0, 1'b1);
    r_v_i = 1'b0;
    do_read(9'd7, 2'd0);
    check("row7_57", {24'd0, r_val_o}, 32'h57);

    // 5: read data held while r_v_i low
    do_read(9'd3, 2'd0);
    for (int k = 0; k < 5; k++) begin
      do_write("yumi_w9", 9'd9, 2'd2, 8'h55, 1'b0, 1'b1);
      check("hold_r_val", {24'd0, r_val_o}, 32'h51);
    end
    do_read(9'd9, 2'd2);
    check("row9_75", {24'd0, r_val_o}, 32'h75);
    check("pred_row9_off2", {31'd0, pred_o}, 32'd1);

    // 6: reset mid-sweep restarts from row 0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 101; k++) tick();
    check("mid_sweep_done", {31'd0, init_done_o}, 32'd0);
    do_write("yumi_in_clear", 9'd20, 2'd0, 8'h55, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_r_val", {24'd0, r_val_o}, 32'h0);
    check("async_rst_done", {31'd0, init_done_o}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    wait_init(n_cyc);
    check("resweep_cycles", n_cyc, 32'd513);
    do_read(9'd7, 2'd0); check("row7_reinit", {24'd0, r_val_o}, 32'h55);
    do_read(9'd9, 2'd0); check("row9_reinit", {24'd0, r_val_o}, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
